console_controller: RTL and testbench

CONSOLE_CONTROLLER -- requirements
Module: console_controller

---
 rtl/console_controller_if.sv | 70 +++++++
 rtl/console_controller.sv | 177 +++++++++++++++++
 tb/tb_console_controller.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/console_controller_if.sv
// +-------------------------------------------------------------------------+
// | console_controller_if : panel, pulse-unit and memory signal bundle      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

interface console_controller_if;
  logic        btn_machine_start;
  logic        btn_clear_pulse;
  logic        btn_do_read_mem;
  logic        btn_do_write_mem;
  logic        btn_write_reg;
  logic        btn_clear_reg_c;
  logic        btn_clear_reg_select;
  logic        btn_clear_reg_start;
  logic        switch_auto_enable;
  logic        switch_stop_at_enable;
  logic        switch_select_or_start;
  logic        switch_arr_reg_c;
  logic        switch_arr_reg_select;
  logic        switch_arr_reg_start;
  logic [30:0] input_reg_c_value;
  logic [11:0] input_reg_select_value;
  logic [11:0] input_reg_start_value;
  logic [11:0] reg_start_value;
  logic [11:0] reg_select_value;
  logic        instr_done;
  logic        mem_finish;
  logic        do_start;
  logic        do_arr_c;
  logic        do_arr_reg_select;
  logic        do_arr_reg_start;
  logic [30:0] arr_reg_c_value;
  logic [11:0] arr_reg_select_data;
  logic [11:0] arr_reg_start_data;
  logic        me_read_enable;
  logic        me_write_enable;
  logic        mem_to_c_enable;
  logic        running;
  logic        err_timeout;
  logic [2:0]  state_code;

  modport master (
    output btn_machine_start, btn_clear_pulse, btn_do_read_mem, btn_do_write_mem,
           btn_write_reg, btn_clear_reg_c, btn_clear_reg_select, btn_clear_reg_start,
           switch_auto_enable, switch_stop_at_enable, switch_select_or_start,
           switch_arr_reg_c, switch_arr_reg_select, switch_arr_reg_start,
           input_reg_c_value, input_reg_select_value, input_reg_start_value,
           reg_start_value, reg_select_value, instr_done, mem_finish,
    input  do_start, do_arr_c, do_arr_reg_select, do_arr_reg_start,
           arr_reg_c_value, arr_reg_select_data, arr_reg_start_data,
           me_read_enable, me_write_enable, mem_to_c_enable,
           running, err_timeout, state_code
  );

  modport slave (
    input  btn_machine_start, btn_clear_pulse, btn_do_read_mem, btn_do_write_mem,
           btn_write_reg, btn_clear_reg_c, btn_clear_reg_select, btn_clear_reg_start,
           switch_auto_enable, switch_stop_at_enable, switch_select_or_start,
           switch_arr_reg_c, switch_arr_reg_select, switch_arr_reg_start,
           input_reg_c_value, input_reg_select_value, input_reg_start_value,
           reg_start_value, reg_select_value, instr_done, mem_finish,
    output do_start, do_arr_c, do_arr_reg_select, do_arr_reg_start,
           arr_reg_c_value, arr_reg_select_data, arr_reg_start_data,
           me_read_enable, me_write_enable, mem_to_c_enable,
           running, err_timeout, state_code
  );
endinterface

`default_nettype wire

// File: rtl/console_controller.sv
// +-------------------------------------------------------------------------+
// | console_controller : operator-panel sequencer for registers/run/memory  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module console_controller (
  input  wire logic             clk,
  input  wire logic             resetn,
  console_controller_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REGWR   = 3'd1,
    LDSTART = 3'd2,
    RUN     = 3'd3,
    MEMRD   = 3'd4,
    MEMWR   = 3'd5,
    LOADC   = 3'd6
  } state_t;

  localparam logic [7:0] WDOG_LAST = 8'd254;

  state_t      state;
  logic [7:0]  btn_now, btn_prev, events;
  logic        primed, stop_pending;
  logic [7:0]  wdog;
  logic        pulse_start, arr_c, arr_sel, arr_st, rd_en, wr_en, to_c, err;
  logic [30:0] data_c;
  logic [11:0] data_sel, data_st;

  assign btn_now = {bus.btn_machine_start, bus.btn_clear_pulse, bus.btn_do_read_mem,
                    bus.btn_do_write_mem, bus.btn_write_reg, bus.btn_clear_reg_c,
                    bus.btn_clear_reg_select, bus.btn_clear_reg_start};

  // History is only trusted one clock after reset release, so a held button is not an event
  assign events = primed ? (btn_now & ~btn_prev) : 8'd0;

  logic ev_start, ev_clr_pulse, ev_rd, ev_wr, ev_wreg, ev_clr_c, ev_clr_sel, ev_clr_st;
  assign {ev_start, ev_clr_pulse, ev_rd, ev_wr, ev_wreg, ev_clr_c, ev_clr_sel, ev_clr_st} = events;

  logic sel_c, sel_sel, sel_st, reg_event, stop_hit, keep_running;
  assign sel_c     = ev_clr_c   | (ev_wreg & bus.switch_arr_reg_c);
  assign sel_sel   = ev_clr_sel | (ev_wreg & bus.switch_arr_reg_select);
  assign sel_st    = ev_clr_st  | (ev_wreg & bus.switch_arr_reg_start);
  assign reg_event = ev_wreg | ev_clr_c | ev_clr_sel | ev_clr_st;
  assign stop_hit  = bus.switch_stop_at_enable &&
                     (bus.reg_start_value == bus.input_reg_start_value);
  assign keep_running = bus.switch_auto_enable && !stop_pending && !ev_clr_pulse && !stop_hit;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      btn_prev     <= 8'd0;
      primed       <= 1'b0;
      stop_pending <= 1'b0;
      wdog         <= 8'd0;
      pulse_start  <= 1'b0;
      arr_c        <= 1'b0;
      arr_sel      <= 1'b0;
      arr_st       <= 1'b0;
      rd_en        <= 1'b0;
      wr_en        <= 1'b0;
      to_c         <= 1'b0;
      err          <= 1'b0;
      data_c       <= 31'd0;
      data_sel     <= 12'd0;
      data_st      <= 12'd0;
    end else begin
      btn_prev    <= btn_now;
      primed      <= 1'b1;
      pulse_start <= 1'b0;
      arr_c       <= 1'b0;
      arr_sel     <= 1'b0;
      arr_st      <= 1'b0;
      rd_en       <= 1'b0;
      wr_en       <= 1'b0;
      to_c        <= 1'b0;
      if (ev_clr_pulse) stop_pending <= 1'b1;

      case (state)
        IDLE: begin
          if (reg_event) begin
            state   <= REGWR;
            arr_c   <= sel_c;
            arr_sel <= sel_sel;
            arr_st  <= sel_st;
            if (sel_c)   data_c   <= ev_clr_c   ? 31'd0 : bus.input_reg_c_value;
            if (sel_sel) data_sel <= ev_clr_sel ? 12'd0 : bus.input_reg_select_value;
            if (sel_st)  data_st  <= ev_clr_st  ? 12'd0 : bus.input_reg_start_value;
          end else if (ev_rd) begin
            state <= MEMRD;
            rd_en <= 1'b1;
            err   <= 1'b0;
            wdog  <= 8'd0;
          end else if (ev_wr) begin
            state <= MEMWR;
            wr_en <= 1'b1;
            err   <= 1'b0;
            wdog  <= 8'd0;
          end else if (ev_start) begin
            if (bus.switch_select_or_start) begin
              state   <= LDSTART;
              arr_st  <= 1'b1;
              data_st <= bus.reg_select_value;
            end else begin
              state       <= RUN;
              pulse_start <= 1'b1;
            end
          end
        end
        REGWR: begin
          state        <= IDLE;
          stop_pending <= 1'b0;
        end
        LDSTART: begin
          state       <= RUN;
          pulse_start <= 1'b1;
        end
        RUN: begin
          if (bus.instr_done) begin
            if (keep_running) begin
              pulse_start <= 1'b1;
            end else begin
              state        <= IDLE;
              stop_pending <= 1'b0;
            end
          end
        end
        MEMRD, MEMWR: begin
          // A completion coinciding with the last watchdog cycle is still a success
          if (bus.mem_finish) begin
            if (state == MEMRD) begin
              state <= LOADC;
              to_c  <= 1'b1;
            end else begin
              state        <= IDLE;
              stop_pending <= 1'b0;
            end
          end else if (wdog == WDOG_LAST) begin
            state        <= IDLE;
            stop_pending <= 1'b0;
            err          <= 1'b1;
          end else begin
            wdog <= wdog + 8'd1;
          end
        end
        LOADC: begin
          state        <= IDLE;
          stop_pending <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          stop_pending <= 1'b0;
        end
      endcase
    end
  end

  assign bus.do_start            = pulse_start;
  assign bus.do_arr_c            = arr_c;
  assign bus.do_arr_reg_select   = arr_sel;
  assign bus.do_arr_reg_start    = arr_st;
  assign bus.arr_reg_c_value     = data_c;
  assign bus.arr_reg_select_data = data_sel;
  assign bus.arr_reg_start_data  = data_st;
  assign bus.me_read_enable      = rd_en;
  assign bus.me_write_enable     = wr_en;
  assign bus.mem_to_c_enable     = to_c;
  assign bus.running             = (state != IDLE);
  assign bus.err_timeout         = err;
  assign bus.state_code          = state;

endmodule

`default_nettype wire

// File: tb/tb_console_controller.sv
// +-------------------------------------------------------------------------+
// | tb_console_controller : self-checking bench for console_controller      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_console_controller;

  logic clk = 1'b0;
  logic resetn;
  int   tests = 0;
  int   fails = 0;

  console_controller_if ifc();
  console_controller dut (.clk(clk), .resetn(resetn), .bus(ifc));

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, cc, cs, ct, sc, ss, st;
    logic [30:0] vc;
    logic [11:0] vs, vt;
    logic [2:0]  exp_do;
    logic [30:0] exp_c;
    logic [11:0] exp_s, exp_t;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    ifc.btn_machine_start = 0; ifc.btn_clear_pulse = 0; ifc.btn_do_read_mem = 0;
    ifc.btn_do_write_mem = 0; ifc.btn_write_reg = 0; ifc.btn_clear_reg_c = 0;
    ifc.btn_clear_reg_select = 0; ifc.btn_clear_reg_start = 0;
    ifc.switch_auto_enable = 0; ifc.switch_stop_at_enable = 0; ifc.switch_select_or_start = 0;
    ifc.switch_arr_reg_c = 0; ifc.switch_arr_reg_select = 0; ifc.switch_arr_reg_start = 0;
    ifc.input_reg_c_value = '0; ifc.input_reg_select_value = '0; ifc.input_reg_start_value = '0;
    ifc.reg_start_value = '0; ifc.reg_select_value = '0; ifc.instr_done = 0; ifc.mem_finish = 0;
  endtask

  task automatic reg_op(input vec_t v, input string tag);
    ifc.switch_arr_reg_c = v.sc; ifc.switch_arr_reg_select = v.ss; ifc.switch_arr_reg_start = v.st;
    ifc.input_reg_c_value = v.vc; ifc.input_reg_select_value = v.vs; ifc.input_reg_start_value = v.vt;
    ifc.btn_write_reg = v.wr; ifc.btn_clear_reg_c = v.cc;
    ifc.btn_clear_reg_select = v.cs; ifc.btn_clear_reg_start = v.ct;
    tick();
    check({tag, "_state"}, 32'(ifc.state_code), 32'd1);
    check({tag, "_do"}, 32'({ifc.do_arr_c, ifc.do_arr_reg_select, ifc.do_arr_reg_start}), 32'(v.exp_do));
    if (v.exp_do[2]) check({tag, "_c"}, 32'(ifc.arr_reg_c_value), 32'(v.exp_c));
    if (v.exp_do[1]) check({tag, "_sel"}, 32'(ifc.arr_reg_select_data), 32'(v.exp_s));
    if (v.exp_do[0]) check({tag, "_st"}, 32'(ifc.arr_reg_start_data), 32'(v.exp_t));
    ifc.btn_write_reg = 0; ifc.btn_clear_reg_c = 0;
    ifc.btn_clear_reg_select = 0; ifc.btn_clear_reg_start = 0;
    tick();
    check({tag, "_back"}, 32'({ifc.state_code, ifc.do_arr_c, ifc.do_arr_reg_select, ifc.do_arr_reg_start}), 32'd0);
  endtask

  // Counting model: reg_start_value follows the number of do_start pulses, so the
  // run must end on the instruction whose count equals the stop address.
  task automatic run_auto(input logic [11:0] stop_addr);
    int n = 0;
    int cnt = 0;
    ifc.switch_auto_enable = 1; ifc.switch_stop_at_enable = 1;
    ifc.switch_select_or_start = 0; ifc.input_reg_start_value = stop_addr;
    ifc.reg_start_value = '0;
    ifc.btn_machine_start = 1;
    tick();
    ifc.btn_machine_start = 0;
    for (int cyc = 0; cyc < 400 && ifc.state_code != 3'd0; cyc++) begin
      if (ifc.do_start) begin
        n++;
        ifc.reg_start_value = 12'(n);
        cnt = 3;
      end
      ifc.instr_done = (cnt == 1);
      if (cnt > 0) cnt--;
      tick();
    end
    ifc.instr_done = 0;
    check("auto_pulses", 32'(n), 32'(stop_addr));
    check("auto_idle", 32'({ifc.state_code, ifc.running}), 32'd0);
    ifc.switch_auto_enable = 0; ifc.switch_stop_at_enable = 0;
  endtask

  task automatic mem_op(input logic is_rd, input int delay);
    if (is_rd) ifc.btn_do_read_mem = 1; else ifc.btn_do_write_mem = 1;
    tick();
    ifc.btn_do_read_mem = 0; ifc.btn_do_write_mem = 0;
    check("mem_en", 32'({ifc.me_read_enable, ifc.me_write_enable}), is_rd ? 32'd2 : 32'd1);
    for (int k = 1; k < delay; k++) tick();
    check("mem_wait", 32'(ifc.state_code), is_rd ? 32'd4 : 32'd5);
    ifc.mem_finish = 1;
    tick();
    ifc.mem_finish = 0;
    if (is_rd) begin
      check("mem_to_c", 32'({ifc.state_code, ifc.mem_to_c_enable}), {28'd0, 3'd6, 1'b1});
      tick();
    end
    check("mem_done", 32'({ifc.state_code, ifc.mem_to_c_enable, ifc.err_timeout}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int seen;
    vec_t rv;
    logic [11:0] sa;

    vecs[0] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0, 31'h12345678,12'h111,12'h222, 3'b100, 31'h12345678,12'h0,12'h0};
    vecs[1] = '{1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1, 31'h0,12'h0,12'h0AB, 3'b001, 31'h0,12'h0,12'h0};
    vecs[2] = '{1'b1,1'b0,1'b0,1'b0, 1'b1,1'b1,1'b1, 31'h7FFFFFFF,12'hFFF,12'hABC, 3'b111, 31'h7FFFFFFF,12'hFFF,12'hABC};
    vecs[3] = '{1'b0,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0, 31'h5555,12'h0,12'h0, 3'b100, 31'h0,12'h0,12'h0};
    vecs[4] = '{1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0, 31'h1,12'h123,12'h0, 3'b110, 31'h1,12'h0,12'h0};
    vecs[5] = '{1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0, 31'h3,12'h4,12'h5, 3'b000, 31'h0,12'h0,12'h0};
    vecs[6] = '{1'b1,1'b1,1'b1,1'b1, 1'b1,1'b1,1'b1, 31'h2AAA,12'h777,12'h888, 3'b111, 31'h0,12'h0,12'h0};

    clear_inputs();
    resetn = 1;
    #2 resetn = 0;
    #1;
    check("reset_async", 32'({ifc.state_code, ifc.running, ifc.err_timeout, ifc.do_start,
                              ifc.me_read_enable, ifc.me_write_enable, ifc.mem_to_c_enable}), 32'd0);
    check("reset_data", 32'(ifc.arr_reg_c_value) | 32'(ifc.arr_reg_select_data) |
                        32'(ifc.arr_reg_start_data), 32'd0);
    tick(); tick();
    resetn = 1;
    tick();

    // Directed register writes and clears
    for (int i = 0; i < 7; i++) reg_op(vecs[i], "vec");

    // Randomised register writes against the select/clear rules
    for (int i = 0; i < 16; i++) begin
      rv.wr = 1'($urandom_range(0, 1)); rv.cc = 1'($urandom_range(0, 1));
      rv.cs = 1'($urandom_range(0, 1)); rv.ct = 1'($urandom_range(0, 1));
      if (!(rv.wr || rv.cc || rv.cs || rv.ct)) rv.wr = 1;
      rv.sc = 1'($urandom_range(0, 1)); rv.ss = 1'($urandom_range(0, 1)); rv.st = 1'($urandom_range(0, 1));
      rv.vc = 31'($urandom); rv.vs = 12'($urandom); rv.vt = 12'($urandom);
      rv.exp_do = {rv.cc | (rv.wr & rv.sc), rv.cs | (rv.wr & rv.ss), rv.ct | (rv.wr & rv.st)};
      rv.exp_c = rv.cc ? 31'd0 : rv.vc;
      rv.exp_s = rv.cs ? 12'd0 : rv.vs;
      rv.exp_t = rv.ct ? 12'd0 : rv.vt;
      reg_op(rv, "rnd_reg");
    end

    // LDSTART path
    ifc.switch_select_or_start = 1; ifc.reg_select_value = 12'h3C5;
    ifc.btn_machine_start = 1;
    tick();
    ifc.btn_machine_start = 0;
    check("ld_state", 32'({ifc.state_code, ifc.do_arr_reg_start, ifc.do_start}), {27'd0, 3'd2, 1'b1, 1'b0});
    check("ld_data", 32'(ifc.arr_reg_start_data), 32'h3C5);
    tick();
    check("ld_run", 32'({ifc.state_code, ifc.do_start, ifc.do_arr_reg_start}), {27'd0, 3'd3, 1'b1, 1'b0});
    ifc.switch_select_or_start = 0;
    // Buttons are dropped outside IDLE
    ifc.btn_write_reg = 1; ifc.switch_arr_reg_c = 1; ifc.btn_do_read_mem = 1;
    tick();
    ifc.btn_write_reg = 0; ifc.switch_arr_reg_c = 0; ifc.btn_do_read_mem = 0;
    check("run_drop", 32'({ifc.state_code, ifc.do_arr_c, ifc.me_read_enable}), {27'd0, 3'd3, 2'b00});
    ifc.instr_done = 1;
    tick();
    ifc.instr_done = 0;
    check("single_end", 32'({ifc.state_code, ifc.do_start, ifc.running}), 32'd0);
    ifc.instr_done = 1;
    tick();
    ifc.instr_done = 0;
    check("idle_instr_done", 32'({ifc.state_code, ifc.do_start}), 32'd0);

    // Auto runs with stop-at address
    run_auto(12'h005);
    sa = 12'($urandom_range(2, 9));
    run_auto(sa);

    // Clear-pulse during an auto run: finishes the instruction, then stops
    ifc.switch_auto_enable = 1;
    ifc.btn_machine_start = 1;
    tick();
    ifc.btn_machine_start = 0;
    check("cp_first", 32'(ifc.do_start), 32'd1);
    tick();
    ifc.btn_clear_pulse = 1;
    tick();
    ifc.btn_clear_pulse = 0;
    tick();
    check("cp_not_abort", 32'({ifc.state_code, ifc.running}), {28'd0, 3'd3, 1'b1});
    ifc.instr_done = 1;
    tick();
    ifc.instr_done = 0;
    check("cp_stop", 32'({ifc.do_start, ifc.running}), 32'd0);
    ifc.switch_auto_enable = 0;

    // Same-cycle priority
    ifc.btn_do_read_mem = 1; ifc.btn_do_write_mem = 1; ifc.btn_machine_start = 1;
    tick();
    ifc.btn_do_read_mem = 0; ifc.btn_do_write_mem = 0; ifc.btn_machine_start = 0;
    check("prio_rd", 32'({ifc.state_code, ifc.me_read_enable, ifc.me_write_enable, ifc.do_start}),
          {27'd0, 3'd4, 2'b10, 1'b0});
    ifc.mem_finish = 1;
    tick();
    ifc.mem_finish = 0;
    tick();
    ifc.btn_write_reg = 1; ifc.btn_do_read_mem = 1;
    tick();
    ifc.btn_write_reg = 0; ifc.btn_do_read_mem = 0;
    check("prio_reg", 32'({ifc.state_code, ifc.me_read_enable}), {28'd0, 3'd1, 1'b0});
    tick();

    // Read with finish three cycles after the enable, then randomised transactions
    mem_op(1'b1, 3);
    for (int i = 0; i < 10; i++) mem_op(1'($urandom_range(0, 1)), int'($urandom_range(1, 30)));

    // Write watchdog expiry
    ifc.btn_do_write_mem = 1;
    tick();
    ifc.btn_do_write_mem = 0;
    cnt = 0;
    for (int k = 0; k < 400 && ifc.state_code == 3'd5; k++) begin
      cnt++;
      tick();
    end
    check("wd_cycles", 32'(cnt), 32'd255);
    check("wd_err", 32'({ifc.state_code, ifc.err_timeout}), 32'd1);
    tick();
    check("wd_err_sticky", 32'(ifc.err_timeout), 32'd1);
    ifc.btn_do_read_mem = 1;
    tick();
    ifc.btn_do_read_mem = 0;
    check("wd_err_clear", 32'({ifc.err_timeout, ifc.me_read_enable}), 32'd1);
    ifc.mem_finish = 1;
    tick();
    ifc.mem_finish = 0;
    tick();

    // Finish on the expiry cycle counts as success
    ifc.btn_do_write_mem = 1;
    tick();
    ifc.btn_do_write_mem = 0;
    for (int k = 1; k < 255; k++) tick();
    check("wd_edge_wait", 32'(ifc.state_code), 32'd5);
    ifc.mem_finish = 1;
    tick();
    ifc.mem_finish = 0;
    check("wd_edge_ok", 32'({ifc.state_code, ifc.err_timeout}), 32'd0);

    // Reset mid-run with the start button held through release
    ifc.switch_auto_enable = 1;
    ifc.btn_machine_start = 1;
    tick();
    tick();
    #2 resetn = 0;
    #1;
    check("rst_mid_run", 32'({ifc.state_code, ifc.running, ifc.do_start}), 32'd0);
    tick(); tick();
    resetn = 1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen = seen | int'(ifc.do_start) | int'(ifc.state_code != 3'd0);
    end
    check("rst_held_btn", 32'(seen), 32'd0);
    ifc.btn_machine_start = 0;
    tick();
    ifc.btn_machine_start = 1;
    tick();
    ifc.btn_machine_start = 0;
    check("rst_new_event", 32'(ifc.do_start), 32'd1);
    ifc.switch_auto_enable = 0;
    ifc.instr_done = 1;
    tick();
    ifc.instr_done = 0;

    // Reset mid-read abandons the transfer
    ifc.btn_do_read_mem = 1;
    tick();
    ifc.btn_do_read_mem = 0;
    #2 resetn = 0;
    #1;
    check("rst_mid_rd", 32'({ifc.state_code, ifc.me_read_enable}), 32'd0);
    tick();
    resetn = 1;
    ifc.mem_finish = 1;
    tick();
    ifc.mem_finish = 0;
    tick();
    check("rst_rd_quiet", 32'({ifc.state_code, ifc.mem_to_c_enable, ifc.do_start}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
